// File: rtl/tdc_bus_responder.sv
`timescale 1ns/1ps
// tdc_bus_responder
// Stands in for the TDC chip on its parallel host bus. Host strobes are
// registered once, edge-detected and decoded into a 16-entry register
// file. Address 8 is the result FIFO, and a read of it pops one entry.
// Address 12 is a read-only status word. A two-state machine times the
// interval between TDC_start and TDC_stop rising edges and pushes the
// result into the FIFO.
//
// Ports:
//   clk        system clock; all inputs are sampled on its rising edge
//   reset_n    asynchronous active-low reset
//   CSN/WRN/RDN  chip select, write strobe and read strobe (active low)
//   addr       register address
//   data_in    host write data
//   data_out   read data (combinational while a read is active)
//   data_oe    drive enable for the external tristate data pins
//   TDC_start  measurement start (rising edge)
//   TDC_stop   measurement stop (rising edge)
//   EF1        result FIFO empty flag, high = empty (registered)
module tdc_bus_responder #(
  parameter int DATA_W     = 28,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              CSN,
  input  logic              WRN,
  input  logic              RDN,
  input  logic [3:0]        addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  input  logic              TDC_start,
  input  logic              TDC_stop,
  output logic              EF1
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]       DEPTH_C   = (AW+1)'(FIFO_DEPTH);
  localparam logic [3:0]        ADDR_CTRL = 4'd0;
  localparam logic [3:0]        ADDR_FIFO = 4'd8;
  localparam logic [3:0]        ADDR_STAT = 4'd12;
  localparam logic [DATA_W-1:0] CNT_MAX   = {DATA_W{1'b1}};

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  // Input sample stage and one-cycle history for edge detection
  logic              csn_r, wrn_r, rdn_r, start_r, stop_r;
  logic              wrn_d_r, rdn_d_r, start_d_r, stop_d_r;
  logic [3:0]        waddr_r;
  logic [DATA_W-1:0] wdata_r;

  // Register file, measurement state and result FIFO
  logic [DATA_W-1:0] regs_r [16];
  state_t            state_r;
  logic [DATA_W-1:0] cnt_r;
  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_r, rd_ptr_r;
  logic [AW:0]       count_r;
  logic              ovf_r;
  logic              ef1_r;

  // Decoded events for the current cycle
  logic              wr_fire_s, rd_rise_s, start_rise_s, stop_rise_s;
  logic              enable_s, clr_s, pop_s, push_s, full_s, push_ok_s;
  logic [AW:0]       count_nxt_s;
  logic [3:0]        occ_s;
  logic [DATA_W-1:0] status_s;

  // Register the bus strobes, write payload and TDC pins; keep one cycle of history
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csn_r     <= 1'b1;
      wrn_r     <= 1'b1;
      rdn_r     <= 1'b1;
      start_r   <= 1'b0;
      stop_r    <= 1'b0;
      wrn_d_r   <= 1'b1;
      rdn_d_r   <= 1'b1;
      start_d_r <= 1'b0;
      stop_d_r  <= 1'b0;
      waddr_r   <= 4'd0;
      wdata_r   <= {DATA_W{1'b0}};
    end else begin
      csn_r     <= CSN;
      wrn_r     <= WRN;
      rdn_r     <= RDN;
      start_r   <= TDC_start;
      stop_r    <= TDC_stop;
      wrn_d_r   <= wrn_r;
      rdn_d_r   <= rdn_r;
      start_d_r <= start_r;
      stop_d_r  <= stop_r;
      // addr and data travel with the WRN sample so a write uses one consistent snapshot
      waddr_r   <= addr;
      wdata_r   <= data_in;
    end
  end

  // Edge detection and event decode
  always_comb begin
    wr_fire_s    = wrn_d_r & ~wrn_r & ~csn_r;
    rd_rise_s    = ~rdn_d_r & rdn_r & ~csn_r;
    start_rise_s = start_r & ~start_d_r;
    stop_rise_s  = stop_r & ~stop_d_r;
    enable_s     = regs_r[0][0];
    clr_s        = wr_fire_s & (waddr_r == ADDR_CTRL) & wdata_r[1];
    full_s       = (count_r == DEPTH_C);
    // pop uses the live addr; the host keeps it stable past the RDN rise
    pop_s        = rd_rise_s & (addr == ADDR_FIFO) & (count_r != {(AW+1){1'b0}});
    push_s       = (state_r == ST_RUN) & enable_s & stop_rise_s;
    // a push into a full FIFO is dropped even if a pop frees a slot in the same cycle
    push_ok_s    = push_s & ~full_s;
  end

  // Next FIFO occupancy: clear beats everything, simultaneous push and pop cancel
  always_comb begin
    count_nxt_s = count_r;
    if (clr_s) begin
      count_nxt_s = {(AW+1){1'b0}};
    end else if (push_ok_s && !pop_s) begin
      count_nxt_s = count_r + 1'b1;
    end else if (pop_s && !push_ok_s) begin
      count_nxt_s = count_r - 1'b1;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Host writes into the register file; FIFO and status addresses are not writable
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_fire_s && (waddr_r != ADDR_FIFO) && (waddr_r != ADDR_STAT)) begin
      if (waddr_r == ADDR_CTRL) begin
        // FIFO_CLR acts only as a pulse and never reads back as 1
        regs_r[0] <= wdata_r & ~{{(DATA_W-2){1'b0}}, 2'b10};
      end else begin
        regs_r[waddr_r] <= wdata_r;
      end
    end
  end

  // Measurement state machine: IDLE/RUN with a saturating interval counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          // start wins over a coincident stop when idle
          if (start_rise_s && enable_s) begin
            state_r <= ST_RUN;
            cnt_r   <= {DATA_W{1'b0}};
          end
        end
        ST_RUN: begin
          if (!enable_s) begin
            state_r <= ST_IDLE;
          end else if (stop_rise_s) begin
            // stop wins over a coincident start while running; cnt_r is pushed this cycle
            state_r <= ST_IDLE;
          end else if (start_rise_s) begin
            cnt_r <= {DATA_W{1'b0}};
          end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= {DATA_W{1'b0}};
        end
      endcase
    end
  end

  // Result FIFO storage, pointers, sticky overflow and registered empty flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      ovf_r    <= 1'b0;
      count_r  <= {(AW+1){1'b0}};
      ef1_r    <= 1'b1;
    end else begin
      if (clr_s) begin
        wr_ptr_r <= {AW{1'b0}};
        rd_ptr_r <= {AW{1'b0}};
        ovf_r    <= 1'b0;
      end else begin
        if (push_ok_s) begin
          mem_r[wr_ptr_r] <= cnt_r;
          wr_ptr_r        <= wr_ptr_r + 1'b1;
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + 1'b1;
        end
        if (push_s && full_s) begin
          ovf_r <= 1'b1;
        end
      end
      count_r <= count_nxt_s;
      ef1_r   <= (count_nxt_s == {(AW+1){1'b0}});
    end
  end

  // Status reports the low 4 bits of the occupancy
  if (AW >= 3) begin : g_occ_wide
    assign occ_s = count_r[3:0];
  end else begin : g_occ_narrow
    assign occ_s = {{(3-AW){1'b0}}, count_r};
  end

  assign status_s = {{(DATA_W-5){1'b0}}, occ_s, ovf_r};

  // Read mux: drive the bus only while the registered CSN and RDN are both low
  always_comb begin
    data_out = {DATA_W{1'b0}};
    data_oe  = 1'b0;
    if (!csn_r && !rdn_r) begin
      data_oe = 1'b1;
      case (addr)
        ADDR_FIFO: data_out = (count_r != {(AW+1){1'b0}}) ? mem_r[rd_ptr_r] : {DATA_W{1'b0}};
        ADDR_STAT: data_out = status_s;
        default:   data_out = regs_r[addr];
      endcase
    end else begin
      data_out = {DATA_W{1'b0}};
      data_oe  = 1'b0;
    end
  end

  assign EF1 = ef1_r;

endmodule

// File: tb/tb_tdc_bus_responder.sv
`timescale 1ns/1ps
module tb_tdc_bus_responder;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        CSN = 1'b1, WRN = 1'b1, RDN = 1'b1;
  logic [3:0]  addr = 4'd0;
  logic [27:0] data_in = 28'd0;
  logic [27:0] data_out;
  logic        data_oe;
  logic        TDC_start = 1'b0, TDC_stop = 1'b0;
  logic        EF1;

  int errors = 0;
  int checks = 0;

  tdc_bus_responder #(.DATA_W(28), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .CSN(CSN), .WRN(WRN), .RDN(RDN),
    .addr(addr), .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
    .TDC_start(TDC_start), .TDC_stop(TDC_stop), .EF1(EF1)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  // Pins seen at a clock edge become events acted on at the following edge.
  logic [27:0] q[$];
  logic [27:0] mregs [16];
  bit          m_ovf, m_run;
  longint      cyc, m_t0;
  bit          s_csn, s_wrn, s_rdn, s_st, s_sp;     // pins seen at the last edge
  bit          ev_wr, ev_rd, ev_start, ev_stop;     // events pending for the next edge
  logic [3:0]  ev_waddr;
  logic [27:0] ev_wdata;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      for (int i = 0; i < 16; i++) mregs[i] = 28'd0;
      m_ovf = 0; m_run = 0; cyc = 0; m_t0 = 0;
      s_csn = 1; s_wrn = 1; s_rdn = 1; s_st = 0; s_sp = 0;
      ev_wr = 0; ev_rd = 0; ev_start = 0; ev_stop = 0;
      ev_waddr = 4'd0; ev_wdata = 28'd0;
    end else begin
      bit en, do_push, do_pop, clr, was_full;
      longint res;
      cyc++;
      en = mregs[0][0];
      do_push = 0; res = 0;
      clr = ev_wr && ev_waddr == 4'd0 && ev_wdata[1];
      if (m_run) begin
        if (!en) m_run = 0;
        else if (ev_stop) begin
          res = cyc - m_t0 - 1;
          if (res > 64'h0FFF_FFFF) res = 64'h0FFF_FFFF;
          do_push = 1; m_run = 0;
        end else if (ev_start) m_t0 = cyc;
      end else if (ev_start && en) begin
        m_run = 1; m_t0 = cyc;
      end
      do_pop = ev_rd && addr == 4'd8 && q.size() != 0;
      if (clr) begin
        q.delete(); m_ovf = 0;
      end else begin
        was_full = (q.size() == DEPTH);
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
          if (was_full) m_ovf = 1;
          else q.push_back(28'(res));
        end
      end
      if (ev_wr && ev_waddr != 4'd8 && ev_waddr != 4'd12)
        mregs[ev_waddr] = (ev_waddr == 4'd0) ? (ev_wdata & ~28'h2) : ev_wdata;
      ev_wr    = s_wrn && !WRN && !CSN;
      ev_waddr = addr; ev_wdata = data_in;
      ev_rd    = !s_rdn && RDN && !CSN;
      ev_start = !s_st && TDC_start;
      ev_stop  = !s_sp && TDC_stop;
      s_csn = CSN; s_wrn = WRN; s_rdn = RDN; s_st = TDC_start; s_sp = TDC_stop;
    end
  end

  function automatic logic [27:0] exp_dout();
    if (s_csn || s_rdn) return 28'd0;
    case (addr)
      4'd8:    return (q.size() != 0) ? q[0] : 28'd0;
      4'd12:   return {23'd0, 4'(q.size()), m_ovf};
      default: return mregs[addr];
    endcase
  endfunction

  // per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    checks++;
    if (EF1 !== (q.size() == 0)) begin
      errors++; $display("FAIL ef1 @%0t: got %b expected %b", $time, EF1, q.size() == 0);
    end
    checks++;
    if (data_oe !== (!s_csn && !s_rdn)) begin
      errors++; $display("FAIL data_oe @%0t: got %b expected %b", $time, data_oe, !s_csn && !s_rdn);
    end
    checks++;
    if (data_out !== exp_dout()) begin
      errors++; $display("FAIL data_out @%0t addr=%0d: got %h expected %h", $time, addr, data_out, exp_dout());
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(input string name, input logic [27:0] act, input logic [27:0] exp);
    checks++;
    if (act !== exp) begin
      errors++; $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [27:0] d);
    addr = a; data_in = d; CSN = 1'b0; tick();
    WRN = 1'b0; tick(); tick();
    WRN = 1'b1; tick();
    CSN = 1'b1; tick();
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [27:0] d, output logic oe);
    addr = a; CSN = 1'b0; RDN = 1'b0; tick(); tick();
    d = data_out; oe = data_oe;
    RDN = 1'b1; tick(); tick(); tick();
    CSN = 1'b1; tick();
  endtask

  // start edge, then stop edge n cycles later
  task automatic meas(input int n);
    TDC_start = 1'b1; tick(); TDC_start = 1'b0;
    repeat (n - 1) tick();
    TDC_stop = 1'b1; tick(); TDC_stop = 1'b0;
    tick(); tick();
  endtask

  logic [27:0] rd;
  logic        oe;

  initial begin
    repeat (3) tick();
    chk("reset_ef1", 28'(EF1), 28'd1);
    chk("reset_oe", 28'(data_oe), 28'd0);
    reset_n = 1'b1; tick();

    // register write/read, status is read-only
    bus_write(4'd3, 28'h0ABCDEF);
    bus_read(4'd3, rd, oe);
    chk("reg3_data", rd, 28'h0ABCDEF);
    chk("reg3_oe", 28'(oe), 28'd1);
    bus_write(4'd12, 28'h0FFFFFF);
    bus_read(4'd12, rd, oe);
    chk("status_ro", rd, 28'd0);

    // one measurement of 100 cycles
    bus_write(4'd0, 28'd1);
    meas(100);
    chk("ef1_after_push", 28'(EF1), 28'd0);
    bus_read(4'd8, rd, oe);
    chk("result_99", rd, 28'd99);
    chk("ef1_after_pop", 28'(EF1), 28'd1);

    // disabled: no push
    bus_write(4'd0, 28'd0);
    meas(10);
    chk("disabled_ef1", 28'(EF1), 28'd1);
    bus_read(4'd8, rd, oe);
    chk("empty_read", rd, 28'd0);

    // overflow: DEPTH+1 measurements, then drain in order
    bus_write(4'd0, 28'd1);
    for (int i = 0; i <= DEPTH; i++) meas(5 + i);
    bus_read(4'd12, rd, oe);
    chk("status_full_ovf", rd, 28'h11);
    for (int i = 0; i < DEPTH; i++) begin
      bus_read(4'd8, rd, oe);
      chk($sformatf("fifo_order%0d", i), rd, 28'(4 + i));
    end
    bus_read(4'd12, rd, oe);
    chk("status_ovf_sticky", rd, 28'h01);
    meas(3); meas(4);
    bus_read(4'd12, rd, oe);
    chk("status_two", rd, 28'h05);
    bus_write(4'd0, 28'd3);
    bus_read(4'd12, rd, oe);
    chk("status_cleared", rd, 28'd0);
    chk("ef1_cleared", 28'(EF1), 28'd1);
    bus_read(4'd0, rd, oe);
    chk("clr_selfclear", rd, 28'd1);

    // coincident start and stop from IDLE: enter RUN, no push
    TDC_start = 1'b1; TDC_stop = 1'b1; tick();
    TDC_start = 1'b0; TDC_stop = 1'b0; tick(); tick();
    chk("same_edge_nopush", 28'(EF1), 28'd1);
    TDC_stop = 1'b1; tick(); TDC_stop = 1'b0; tick(); tick();
    chk("same_edge_was_run", 28'(EF1), 28'd0);
    meas(7); meas(8);
    bus_read(4'd12, rd, oe);
    chk("status_three", rd, 28'h06);

    // push and pop in the same cycle at occupancy 3
    TDC_start = 1'b1; tick(); TDC_start = 1'b0; tick(); tick();
    addr = 4'd8; CSN = 1'b0; RDN = 1'b0; tick(); tick();
    RDN = 1'b1; TDC_stop = 1'b1; tick();
    TDC_stop = 1'b0; tick(); tick(); tick();
    CSN = 1'b1; tick();
    bus_read(4'd12, rd, oe);
    chk("push_pop_same", rd, 28'h06);

    // randomized traffic against the model
    for (int it = 0; it < 300; it++) begin
      int op;
      op = $urandom_range(0, 9);
      case (op)
        0, 1: begin
          logic [3:0] a;
          logic [27:0] d;
          a = 4'($urandom_range(0, 15));
          d = 28'($urandom());
          if (a == 4'd0) d = {26'($urandom()), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) != 0)};
          bus_write(a, d);
        end
        2, 3, 4: begin
          logic [3:0] a;
          int r;
          r = $urandom_range(0, 3);
          a = (r < 2) ? 4'd8 : (r == 2) ? 4'd12 : 4'($urandom_range(0, 15));
          bus_read(a, rd, oe);
        end
        5, 6: begin
          TDC_start = 1'b1; tick(); TDC_start = 1'b0;
          repeat ($urandom_range(0, 12)) tick();
        end
        7: begin
          TDC_stop = 1'b1; tick(); TDC_stop = 1'b0;
          repeat ($urandom_range(0, 4)) tick();
        end
        8: begin
          TDC_start = 1'b1; TDC_stop = 1'b1; tick();
          TDC_start = 1'b0; TDC_stop = 1'b0; tick();
        end
        default: repeat ($urandom_range(1, 6)) tick();
      endcase
    end

    // asynchronous reset in the middle of a run with results queued
    bus_write(4'd0, 28'd1);
    bus_write(4'd0, 28'd3);
    meas(6); meas(9);
    TDC_start = 1'b1; tick(); TDC_start = 1'b0;
    repeat (5) tick();
    addr = 4'd12; CSN = 1'b0; RDN = 1'b0; tick(); tick();
    chk("pre_reset_status", data_out, 28'h04);
    reset_n = 1'b0; #1;
    chk("async_ef1", 28'(EF1), 28'd1);
    chk("async_oe", 28'(data_oe), 28'd0);
    chk("async_dout", data_out, 28'd0);
    CSN = 1'b1; RDN = 1'b1; tick(); tick();
    reset_n = 1'b1; tick();
    bus_read(4'd12, rd, oe);
    chk("post_reset_status", rd, 28'd0);
    bus_read(4'd0, rd, oe);
    chk("post_reset_reg0", rd, 28'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
